fc_layer_engine: RTL and testbench
==================================

Name: fc_layer_engine

Overview:
- Parametrised fully-connected layer engine; successor to the fixed 84-in/10-out FC stage of the LeNet5 pipeline.
- Inputs arrive as a stream, not as parallel ports, and are buffered locally.
- NUM_OUT parallel MAC lanes each sweep IN_DEPTH weights, add a bias, apply optional ReLU and saturation, then emit results serially through a valid/ready handshake.
- Weights and biases are loaded by the RISC-V host port, as in the existing FC stages.

Parameters:
- DATA_WIDTH, 32, signed fixed-point word width for data, weights and biases.
- FRAC_BITS, 16, number of fractional bits (Q format).
- IN_DEPTH, 84, input vector length.
- NUM_OUT, 10, number of output neurons (MAC lanes).
- ADDRESS_BITS, 15, host address width; must be at least max($clog2(IN_DEPTH), $clog2(NUM_OUT)).
- RELU_EN, 1, reset/default value of the ReLU mode bit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- riscv_data  in  DATA_WIDTH  host write data
- riscv_address  in  ADDRESS_BITS  host write address
- wm_enable_write  in  NUM_OUT  one-hot weight-memory write strobe per lane
- bm_enable_write  in  1  bias write strobe; lane index = riscv_address
- relu_mode  in  1  sampled at start: 1 = ReLU, 0 = linear
- start  in  1  one-cycle request to begin a layer pass
- ifm_data  in  DATA_WIDTH  input feature word
- ifm_valid  in  1  ifm_data valid
- ifm_ready  out  1  engine accepts an ifm word
- out_data  out  DATA_WIDTH  result word
- out_index  out  $clog2(NUM_OUT)  neuron index of out_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts a result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; all counters and accumulators clear; ifm_ready=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0. Weight and bias memory contents are not cleared.
- Host writes:
  - Accepted only in IDLE; writes in any other state are dropped silently.
  - wm_enable_write[n] writes riscv_data to lane n at address riscv_address[$clog2(IN_DEPTH)-1:0]. Addresses >= IN_DEPTH are ignored.
  - Several wm bits may be set together; each selected lane gets the same word.
  - bm_enable_write writes bias[riscv_address]; an index >= NUM_OUT is ignored.
- FSM states and transitions:
  - IDLE: start -> LOAD; relu_mode is latched on this edge. start in any other state is ignored.
  - LOAD: ifm_ready=1. Each cycle with ifm_valid&ifm_ready writes ifm_buf[cnt] and increments cnt. After word IN_DEPTH-1 -> MAC, with accumulators cleared. ifm_ready drops in the cycle after the last accept.
  - MAC: IN_DEPTH+1 cycles.
    - Cycle k (0..IN_DEPTH-1) issues the synchronous read of ifm_buf[k] and of every lane's weight[k].
    - Cycle k+1 performs acc_n += ifm*w_n as a full 2*DATA_WIDTH signed product.
    - Accumulator width is 2*DATA_WIDTH+$clog2(IN_DEPTH), so no overflow is possible.
  - FINAL: 1 cycle. r_n = (acc_n >>> FRAC_BITS) + sign-extended bias_n. If ReLU is latched and r_n<0, r_n=0. Saturate r_n to the DATA_WIDTH signed range and store into res_n.
  - OUT: out_valid=1, out_data=res[idx], out_index=idx. Each out_valid&out_ready handshake advances idx. out_data and out_index stay stable while out_ready=0. After idx NUM_OUT-1 is accepted -> IDLE with done=1 for that one cycle.
- Latency from start to the first out_valid, with ifm_valid held high: IN_DEPTH + IN_DEPTH+1 + 1 + 1 cycles (LOAD entry + MAC + FINAL + OUT entry).
- Back-to-back passes: start asserted in the same cycle done pulses is ignored (the FSM is not yet in IDLE); start in the next cycle is accepted.
- ifm_valid gaps in LOAD stall without loss. ifm_valid outside LOAD is ignored.
- Reset asserted mid-pass aborts the pass immediately with all outputs at their reset values; the next start runs a clean pass.

Decomposition:
- Shared package fc_pkg:
  - FSM state enum (IDLE, LOAD, MAC, FINAL, OUT).
  - Accumulator-width function.
  - Signed saturation function.
- One sub-module, fc_mac_lane:
  - Weight memory (IN_DEPTH x DATA_WIDTH, one synchronous read port and one write port) and bias register.
  - Accumulator and FINAL-stage bias/ReLU/saturation.
  - Instantiated NUM_OUT times in a generate loop.
- The top level holds the FSM, ifm_buf, counters and output mux.

Test Plan:
- Load IN_DEPTH=4, NUM_OUT=2, FRAC_BITS=16; weights lane0=1.0 all, lane1=-0.5 all; bias 0; ifm=1.0,2.0,3.0,4.0; relu_mode=0 -> out 0x000A0000 at index 0, then 0xFFFB0000 (-5.0) at index 1, then done pulses.
- Same vectors with relu_mode=1 -> lane1 output 0x00000000; lane0 unchanged.
- Weights 0x7FFFFFFF, ifm 0x7FFFFFFF, bias 0x7FFFFFFF -> out saturates to 0x7FFFFFFF; with ifm negated -> 0x80000000 in linear mode.
- Hold out_ready=0 for 5 cycles in OUT -> out_data and out_index stable, out_valid held; random ifm_valid gaps in LOAD -> same results as the gap-free run.
- Host weight write during MAC -> ignored; rerun gives identical results. start during OUT -> ignored.
- Assert reset at MAC cycle 2 -> all outputs 0 within the same cycle; a new start plus reload of ifm gives correct results with weights preserved.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FSM encoding and fixed-point helpers for the fully-connected layer engine.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_FINAL,
    ST_OUT
  } fc_state_e;

  // Wide scratch width for post-accumulate arithmetic; must exceed the accumulator width.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int data_width, input int in_depth);
    return 2 * data_width + $clog2(in_depth);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                        input int data_width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) << (data_width - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: weight memory, bias register, wide accumulator and the
// final shift / bias / ReLU / saturation stage.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int IN_DEPTH   = 84
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_we,
  input  logic [$clog2(IN_DEPTH)-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic                          b_we,
  input  logic [DATA_WIDTH-1:0]         b_data,
  input  logic [$clog2(IN_DEPTH)-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]         ifm_q,
  input  logic                          acc_clr,
  input  logic                          acc_en,
  input  logic                          final_en,
  input  logic                          relu,
  output logic [DATA_WIDTH-1:0]         res
);

  localparam int ACC_W = acc_width(DATA_WIDTH, IN_DEPTH);

  logic [DATA_WIDTH-1:0]         wmem [IN_DEPTH];
  logic [DATA_WIDTH-1:0]         w_q;
  logic [DATA_WIDTH-1:0]         bias;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]       acc;
  logic signed [SAT_W-1:0]       r_wide;
  logic signed [SAT_W-1:0]       r_sat;
  logic                          sat_unused;

  // Weights and bias are host state: they survive reset.
  always_ff @(posedge clk) begin
    if (w_we) wmem[w_addr] <= w_data;
    if (b_we) bias <= b_data;
    w_q <= wmem[rd_addr];
  end

  assign prod = $signed(ifm_q) * $signed(w_q);

  always_comb begin
    r_wide = SAT_W'(acc >>> FRAC_BITS) + SAT_W'($signed(bias));
    if (relu && r_wide[SAT_W-1]) r_wide = '0;
    r_sat = sat_signed(r_wide, DATA_WIDTH);
  end

  assign sat_unused = ^r_sat[SAT_W-1:DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= acc + ACC_W'(prod);
      if (final_en)    res <= r_sat[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Streamed-input fully-connected layer: buffers IN_DEPTH words, runs NUM_OUT
// MAC lanes in parallel, then drains results over a valid/ready port.
//   state | meaning
//   IDLE  | host writes allowed, waiting for start
//   LOAD  | accepting ifm words into ifm_buf
//   MAC   | IN_DEPTH+1 cycles: read k, accumulate k-1
//   FINAL | shift, bias, ReLU, saturate into res
//   OUT   | serial result handshake, idx 0..NUM_OUT-1
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 16,
  parameter int IN_DEPTH     = 84,
  parameter int NUM_OUT      = 10,
  parameter int ADDRESS_BITS = 15,
  parameter bit RELU_EN      = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       riscv_data,
  input  logic [ADDRESS_BITS-1:0]     riscv_address,
  input  logic [NUM_OUT-1:0]          wm_enable_write,
  input  logic                        bm_enable_write,
  input  logic                        relu_mode,
  input  logic                        start,
  input  logic [DATA_WIDTH-1:0]       ifm_data,
  input  logic                        ifm_valid,
  output logic                        ifm_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(NUM_OUT)-1:0]  out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = $clog2(IN_DEPTH);
  localparam int CW = $clog2(IN_DEPTH + 1);
  localparam int IW = $clog2(NUM_OUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(IN_DEPTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(IN_DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OUT - 1);

  fc_state_e             state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  relu_q;
  logic                  ifm_fire, out_fire, host_ok;
  logic                  acc_clr, acc_en, final_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] ifm_buf [IN_DEPTH];
  logic [DATA_WIDTH-1:0] ifm_q;
  logic [DATA_WIDTH-1:0] res [NUM_OUT];

  assign ifm_fire = ifm_valid & ifm_ready;
  assign out_fire = out_valid & out_ready;
  assign host_ok  = (state == ST_IDLE);
  assign rd_addr  = (cnt < CNT_END) ? cnt[AW-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (ifm_fire && cnt == CNT_LAST) state_nxt = ST_MAC;
      ST_MAC:   if (cnt == CNT_END) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_OUT;
      ST_OUT:   if (out_fire && idx == IDX_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ifm_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    final_en  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_LOAD: begin
        ifm_ready = 1'b1;
        acc_clr   = 1'b1;
      end
      // First MAC cycle only issues the read; data lands one cycle later.
      ST_MAC:   acc_en = (cnt != '0);
      ST_FINAL: final_en = 1'b1;
      ST_OUT: begin
        out_valid = 1'b1;
        out_data  = res[idx];
        done      = out_ready && (idx == IDX_LAST);
      end
      default: ;
    endcase
  end

  assign out_index = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      relu_q <= RELU_EN;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (start) relu_q <= relu_mode;
        end
        ST_LOAD:  if (ifm_fire) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        ST_MAC:   cnt <= cnt + 1'b1;
        ST_FINAL: begin
          cnt <= '0;
          idx <= '0;
        end
        ST_OUT:   if (out_fire) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ifm_fire) ifm_buf[cnt[AW-1:0]] <= ifm_data;
    ifm_q <= ifm_buf[rd_addr];
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_lane
    logic w_we, b_we;
    assign w_we = host_ok && wm_enable_write[n] &&
                  (riscv_address < ADDRESS_BITS'(IN_DEPTH));
    assign b_we = host_ok && bm_enable_write && (riscv_address == ADDRESS_BITS'(n));

    fc_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .IN_DEPTH   (IN_DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (reset),
      .w_we     (w_we),
      .w_addr   (riscv_address[AW-1:0]),
      .w_data   (riscv_data),
      .b_we     (b_we),
      .b_data   (riscv_data),
      .rd_addr  (rd_addr),
      .ifm_q    (ifm_q),
      .acc_clr  (acc_clr),
      .acc_en   (acc_en),
      .final_en (final_en),
      .relu     (relu_q),
      .res      (res[n])
    );
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine with a 4-input, 2-lane, Q16.16 configuration.
module tb_fc_layer_engine;

  localparam int DW = 32;
  localparam int IN_DEPTH = 4;
  localparam int NUM_OUT = 2;
  localparam int AB = 15;

  typedef struct packed {
    logic [3:0][31:0] w0;
    logic [3:0][31:0] w1;
    logic [3:0][31:0] ifm;
    logic [31:0]      b0;
    logic [31:0]      b1;
    logic             relu;
    logic [31:0]      e0;
    logic [31:0]      e1;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     riscv_data;
  logic [AB-1:0]     riscv_address;
  logic [NUM_OUT-1:0] wm_enable_write;
  logic              bm_enable_write;
  logic              relu_mode;
  logic              start;
  logic [DW-1:0]     ifm_data;
  logic              ifm_valid;
  logic              ifm_ready;
  logic [DW-1:0]     out_data;
  logic              out_index;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  vec_t tbl [6];
  exp_t sbq [$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(
    .DATA_WIDTH   (DW),
    .FRAC_BITS    (16),
    .IN_DEPTH     (IN_DEPTH),
    .NUM_OUT      (NUM_OUT),
    .ADDRESS_BITS (AB),
    .RELU_EN      (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .riscv_data      (riscv_data),
    .riscv_address   (riscv_address),
    .wm_enable_write (wm_enable_write),
    .bm_enable_write (bm_enable_write),
    .relu_mode       (relu_mode),
    .start           (start),
    .ifm_data        (ifm_data),
    .ifm_valid       (ifm_valid),
    .ifm_ready       (ifm_ready),
    .out_data        (out_data),
    .out_index       (out_index),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_w(input logic [NUM_OUT-1:0] lanes, input int addr, input logic [31:0] d);
    riscv_address = AB'(addr);
    riscv_data = d;
    wm_enable_write = lanes;
    @(negedge clk);
    wm_enable_write = '0;
  endtask

  task automatic host_b(input int addr, input logic [31:0] d);
    riscv_address = AB'(addr);
    riscv_data = d;
    bm_enable_write = 1'b1;
    @(negedge clk);
    bm_enable_write = 1'b0;
  endtask

  task automatic load_weights(input int v);
    for (int a = 0; a < IN_DEPTH; a++) begin
      if (tbl[v].w0[a] == tbl[v].w1[a]) host_w(2'b11, a, tbl[v].w0[a]);
      else begin
        host_w(2'b01, a, tbl[v].w0[a]);
        host_w(2'b10, a, tbl[v].w1[a]);
      end
    end
    host_b(0, tbl[v].b0);
    host_b(1, tbl[v].b1);
    // Out-of-range addresses must not alias onto real entries.
    host_w(2'b11, IN_DEPTH, 32'h5555_5555);
    host_b(NUM_OUT, 32'h5555_5555);
  endtask

  task automatic start_pass(input int v);
    exp_t e;
    relu_mode = tbl[v].relu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    relu_mode = ~tbl[v].relu;
    e.d = tbl[v].e0; e.idx = 1'b0; sbq.push_back(e);
    e.d = tbl[v].e1; e.idx = 1'b1; sbq.push_back(e);
    #1;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic feed(input int v, input bit gaps);
    int t;
    for (int i = 0; i < IN_DEPTH; i++) begin
      if (gaps) begin
        ifm_valid = 1'b0;
        ifm_data = 32'hBAD0_0000;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      ifm_valid = 1'b1;
      ifm_data = tbl[v].ifm[i];
      t = 0;
      while (!ifm_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("ifm_ready", 32'(ifm_ready), 32'd1);
      @(negedge clk);
    end
    ifm_valid = 1'b0;
    #1;
    chk("ifm_ready_drop", 32'(ifm_ready), 32'd0);
  endtask

  // mode 0: plain drain; 1: stall first result 5 cycles with a start pulse; 2: start on done cycle
  task automatic collect(input int mode);
    exp_t e;
    int t;
    for (int k = 0; k < NUM_OUT; k++) begin
      t = 0;
      while (!out_valid && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) begin
        n_vec++;
        n_bad++;
        $display("FAIL out_valid_timeout: got 0 expected 1");
        sbq.delete();
        return;
      end
      e = sbq.pop_front();
      chk("out_data", out_data, e.d);
      chk("out_index", 32'(out_index), 32'(e.idx));
      if (mode == 1 && k == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (s == 2) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          #1;
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", out_data, e.d);
          chk("stall_index", 32'(out_index), 32'(e.idx));
          chk("stall_done", 32'(done), 32'd0);
        end
        out_ready = 1'b1;
      end
      if (mode == 2 && k == NUM_OUT - 1) start = 1'b1;
      #1;
      chk("done_pulse", 32'(done), (k == NUM_OUT - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("busy_after_pass", 32'(busy), 32'd0);
    chk("done_after_pass", 32'(done), 32'd0);
  endtask

  task automatic run_pass(input int v, input bit gaps, input int mode);
    start_pass(v);
    feed(v, gaps);
    collect(mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Packed arrays below list element [3] first, element [0] last.
    tbl[0].w0 = {4{32'h0001_0000}};
    tbl[0].w1 = {4{32'hFFFF_8000}};
    tbl[0].ifm = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    tbl[0].b0 = 0; tbl[0].b1 = 0; tbl[0].relu = 1'b0;
    tbl[0].e0 = 32'h000A_0000; tbl[0].e1 = 32'hFFFB_0000;

    tbl[1] = tbl[0];
    tbl[1].relu = 1'b1;
    tbl[1].e1 = 32'h0000_0000;

    tbl[2].w0 = {4{32'h7FFF_FFFF}};
    tbl[2].w1 = {4{32'h7FFF_FFFF}};
    tbl[2].ifm = {4{32'h7FFF_FFFF}};
    tbl[2].b0 = 32'h7FFF_FFFF; tbl[2].b1 = 32'h7FFF_FFFF; tbl[2].relu = 1'b0;
    tbl[2].e0 = 32'h7FFF_FFFF; tbl[2].e1 = 32'h7FFF_FFFF;

    tbl[3] = tbl[2];
    tbl[3].ifm = {4{32'h8000_0001}};
    tbl[3].e0 = 32'h8000_0000; tbl[3].e1 = 32'h8000_0000;

    tbl[4].w0 = {4{32'h0002_0000}};
    tbl[4].w1 = {4{32'h0000_4000}};
    tbl[4].ifm = {32'h0000_8000, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000};
    tbl[4].b0 = 32'h0001_8000; tbl[4].b1 = 32'hFFFD_0000; tbl[4].relu = 1'b0;
    tbl[4].e0 = 32'h0003_8000; tbl[4].e1 = 32'hFFFD_4000;

    tbl[5].w0 = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    tbl[5].w1 = {32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[5].ifm = {32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[5].b0 = 0; tbl[5].b1 = 0; tbl[5].relu = 1'b0;
    tbl[5].e0 = 32'h0008_0000; tbl[5].e1 = 32'hFFFE_0000;

    reset = 1'b1;
    riscv_data = '0; riscv_address = '0; wm_enable_write = '0; bm_enable_write = 1'b0;
    relu_mode = 1'b0; start = 1'b0; ifm_data = '0; ifm_valid = 1'b0; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ifm_ready", 32'(ifm_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      load_weights(v);
      run_pass(v, 1'b0, 0);
    end

    // ifm gaps, output back-pressure and a start pulse while in OUT
    run_pass(5, 1'b1, 1);

    // start on the done cycle is dropped, start on the following cycle is taken
    run_pass(5, 1'b0, 2);
    run_pass(5, 1'b0, 0);

    // host writes while busy are dropped
    load_weights(4);
    start_pass(4);
    feed(4, 1'b0);
    host_w(2'b11, 0, 32'hDEAD_BEEF);
    host_b(0, 32'h1234_0000);
    host_b(1, 32'h1234_0000);
    collect(0);
    run_pass(4, 1'b0, 0);

    // reset in MAC cycle 2 aborts; weights survive
    load_weights(0);
    start_pass(0);
    feed(0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ifm_ready", 32'(ifm_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_index", 32'(out_index), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_pass(0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
